// File: rtl/sample_ntt_dual.sv
// Dual-mode (ML-KEM SampleNTT / ML-DSA RejNTTPoly) streaming rejection sampler.
// Define SAMPLE_NTT_DUAL_STATS_EN to add rej_cnt_o / chunk_cnt_o.
module sample_ntt_dual #(
  parameter int DWIDTH     = 256,
  parameter int KEEP_WIDTH = DWIDTH/8,
  parameter int FIFO_BYTES = 64,
  parameter int N_COEFFS   = 256,
  parameter int Q_KEM      = 3329,
  parameter int Q_DSA      = 8380417
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode_i,
  input  logic                  abort_i,
  output logic                  done,
  output logic                  error_o,
  input  logic [DWIDTH-1:0]     t_data_i,
  input  logic                  t_valid_i,
  input  logic                  t_last_i,
  input  logic [KEEP_WIDTH-1:0] t_keep_i,
  output logic                  t_ready_o,
  output logic [23:0]           t_data_o,
  output logic                  t_valid_o,
  output logic                  t_last_o,
  output logic [2:0]            t_keep_o,
  input  logic                  t_ready_i
`ifdef SAMPLE_NTT_DUAL_STATS_EN
  ,
  output logic [15:0]           rej_cnt_o,
  output logic [15:0]           chunk_cnt_o
`endif
);

  localparam int PW = $clog2(FIFO_BYTES);
  localparam int CW = $clog2(FIFO_BYTES+1);
  localparam int NW = $clog2(N_COEFFS+1);
  localparam int KW = $clog2(KEEP_WIDTH+1);
  localparam logic [11:0] QK = 12'(Q_KEM);
  localparam logic [22:0] QD = 23'(Q_DSA);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          seen_q, seen_d;
  logic [7:0]    mem_q [FIFO_BYTES];
  logic [7:0]    mem_d [FIFO_BYTES];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0] rd1, rd2;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] coef_q, coef_d;
  logic [23:0]   oq_data_q [2];
  logic [23:0]   oq_data_d [2];
  logic [1:0]    oq_last_q, oq_last_d;
  logic [1:0]    oq_cnt_q, oq_cnt_d;

  logic          run, wr_fire, out_valid, out_pop, chunk;
  logic [7:0]    b0, b1, b2;
  logic [11:0]   d1, d2;
  logic [22:0]   dd;
  logic          acc_a, acc_b;
  logic [23:0]   cand_a, cand_b;
  logic [1:0]    n_acc, n_push, oq_free, qn;
  logic [KW-1:0] woff;

  assign run       = state_q == S_RUN;
  assign t_ready_o = run && !seen_q &&
                     cnt_q <= CW'(FIFO_BYTES-KEEP_WIDTH);
  assign wr_fire   = t_valid_i && t_ready_o;
  assign out_valid = oq_cnt_q != 2'd0;
  assign out_pop   = out_valid && t_ready_i;

  assign t_valid_o = out_valid;
  assign t_data_o  = out_valid ? oq_data_q[0] : 24'd0;
  assign t_last_o  = out_valid && oq_last_q[0];
  assign t_keep_o  = out_valid ? 3'b111 : 3'b000;
  assign done      = state_q == S_DONE;
  assign error_o   = done && err_q;

  assign rd1 = rd_q + PW'(1);
  assign rd2 = rd_q + PW'(2);
  assign b0  = mem_q[rd_q];
  assign b1  = mem_q[rd1];
  assign b2  = mem_q[rd2];
  assign d1  = {b1[3:0], b0};
  assign d2  = {b2, b1[7:4]};
  assign dd  = {b2[6:0], b1, b0};

  assign acc_a  = mode_q ? (dd < QD) : (d1 < QK);
  assign acc_b  = !mode_q && (d2 < QK);
  assign cand_a = mode_q ? {1'b0, dd} : {12'd0, d1};
  assign cand_b = {12'd0, d2};
  assign n_acc  = {1'b0, acc_a} + {1'b0, acc_b};

  // Only the coefficients that still fit in the run need queue room.
  assign n_push = (n_acc == 2'd2 &&
                   coef_q == NW'(N_COEFFS-1)) ? 2'd1 : n_acc;
  assign oq_free = 2'd2 - oq_cnt_q + {1'b0, out_pop};
  assign chunk = run && cnt_q >= CW'(3) &&
                 coef_q < NW'(N_COEFFS) && n_push <= oq_free;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    err_d     = err_q;
    seen_d    = seen_q;
    mem_d     = mem_q;
    rd_d      = rd_q;
    coef_d    = coef_q;
    oq_data_d = oq_data_q;
    oq_last_d = oq_last_q;
    woff      = '0;
    qn        = oq_cnt_q;
    if (wr_fire) begin
      for (int k = 0; k < KEEP_WIDTH; k++) begin
        if (t_keep_i[k]) begin
          mem_d[wr_q + PW'(woff)] = t_data_i[8*k +: 8];
          woff = woff + KW'(1);
        end
      end
      seen_d = seen_q | t_last_i;
    end
    wr_d = wr_q + PW'(woff);
    if (chunk) begin
      rd_d   = rd_q + PW'(3);
      coef_d = coef_q + NW'(n_push);
    end
    cnt_d = cnt_q + CW'(woff) - (chunk ? CW'(3) : CW'(0));
    if (out_pop) begin
      oq_data_d[0] = oq_data_q[1];
      oq_last_d[0] = oq_last_q[1];
      qn = qn - 2'd1;
    end
    if (chunk && n_push != 2'd0) begin
      oq_data_d[qn[0]] = acc_a ? cand_a : cand_b;
      oq_last_d[qn[0]] = coef_q == NW'(N_COEFFS-1);
      qn = qn + 2'd1;
    end
    if (chunk && n_push == 2'd2) begin
      oq_data_d[qn[0]] = cand_b;
      oq_last_d[qn[0]] = coef_q == NW'(N_COEFFS-2);
      qn = qn + 2'd1;
    end
    oq_cnt_d = qn;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          mode_d   = mode_i;
          err_d    = 1'b0;
          seen_d   = 1'b0;
          wr_d     = '0;
          rd_d     = '0;
          cnt_d    = '0;
          coef_d   = '0;
          oq_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (coef_d == NW'(N_COEFFS) && qn == 2'd0) begin
          state_d = S_DONE;
          err_d   = 1'b0;
        end else if (seen_d && cnt_d < CW'(3) &&
                     coef_d < NW'(N_COEFFS) && qn == 2'd0) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d  = S_IDLE;
      err_d    = 1'b0;
      seen_d   = 1'b0;
      wr_d     = '0;
      rd_d     = '0;
      cnt_d    = '0;
      coef_d   = '0;
      oq_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      seen_q    <= 1'b0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      coef_q    <= '0;
      oq_data_q <= '{default: '0};
      oq_last_q <= '0;
      oq_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      seen_q    <= seen_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      coef_q    <= coef_d;
      oq_data_q <= oq_data_d;
      oq_last_q <= oq_last_d;
      oq_cnt_q  <= oq_cnt_d;
    end
  end

`ifdef SAMPLE_NTT_DUAL_STATS_EN
  logic [15:0] rej_q, rej_d, chk_q, chk_d;
  logic [1:0]  nrej;
  logic [16:0] rsum;

  assign nrej = {1'b0, !acc_a} + {1'b0, !mode_q && !acc_b};
  assign rsum = {1'b0, rej_q} + 17'(nrej);
  assign rej_cnt_o   = rej_q;
  assign chunk_cnt_o = chk_q;

  always_comb begin
    rej_d = rej_q;
    chk_d = chk_q;
    if (chunk) begin
      rej_d = rsum[16] ? 16'hFFFF : rsum[15:0];
      chk_d = (chk_q == 16'hFFFF) ? chk_q : chk_q + 16'd1;
    end
    if (abort_i || (state_q == S_IDLE && start)) begin
      rej_d = '0;
      chk_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_q <= '0;
      chk_q <= '0;
    end else begin
      rej_q <= rej_d;
      chk_q <= chk_d;
    end
  end
`endif

endmodule

// File: tb/tb_sample_ntt_dual.sv
// Testbench for sample_ntt_dual: directed vector table plus randomized
// streams checked against a byte-list reference model.
module tb_sample_ntt_dual;

  localparam int NC = 256;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mode_i;
  logic          abort_i;
  logic          done;
  logic          error_o;
  logic [255:0]  t_data_i;
  logic          t_valid_i;
  logic          t_last_i;
  logic [31:0]   t_keep_i;
  logic          t_ready_o;
  logic [23:0]   t_data_o;
  logic          t_valid_o;
  logic          t_last_o;
  logic [2:0]    t_keep_o;
  logic          t_ready_i;
`ifdef SAMPLE_NTT_DUAL_STATS_EN
  logic [15:0]   rej_cnt_o;
  logic [15:0]   chunk_cnt_o;
`endif

  sample_ntt_dual dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode_i     (mode_i),
    .abort_i    (abort_i),
    .done       (done),
    .error_o    (error_o),
    .t_data_i   (t_data_i),
    .t_valid_i  (t_valid_i),
    .t_last_i   (t_last_i),
    .t_keep_i   (t_keep_i),
    .t_ready_o  (t_ready_o),
    .t_data_o   (t_data_o),
    .t_valid_o  (t_valid_o),
    .t_last_o   (t_last_o),
    .t_keep_o   (t_keep_o),
    .t_ready_i  (t_ready_i)
`ifdef SAMPLE_NTT_DUAL_STATS_EN
    ,
    .rej_cnt_o  (rej_cnt_o),
    .chunk_cnt_o(chunk_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [255:0] bd [$];
  logic [31:0]  bk [$];
  logic [7:0]   sb [$];
  int unsigned  expq [$];
  bit           exp_err;
  int unsigned  got [$];
  int           lastidx [$];
  int           keep_bad;

  typedef struct {
    bit          mode;
    logic [47:0] bytes;
    int unsigned e0;
    int unsigned e1;
    int          ne;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input longint a,
                     input longint e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, a, e);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_stream();
    bd.delete();
    bk.delete();
    sb.delete();
  endtask

  task automatic add_beat(input logic [255:0] d,
                          input logic [31:0] k);
    bd.push_back(d);
    bk.push_back(k);
    for (int i = 0; i < 32; i++)
      if (k[i]) sb.push_back(d[8*i +: 8]);
  endtask

  // Reference: walk the packed byte list three at a time.
  task automatic run_model(input bit mode);
    int i;
    int unsigned x0, x1, x2, c1, c2;
    expq.delete();
    i = 0;
    while (i + 3 <= sb.size() && expq.size() < NC) begin
      x0 = sb[i];
      x1 = sb[i+1];
      x2 = sb[i+2];
      if (!mode) begin
        c1 = x0 + 256 * (x1 % 16);
        c2 = x1 / 16 + 16 * x2;
        if (c1 < 3329) expq.push_back(c1);
        if (c2 < 3329 && expq.size() < NC) expq.push_back(c2);
      end else begin
        c1 = x0 + 256 * x1 + 65536 * (x2 % 128);
        if (c1 < 8380417) expq.push_back(c1);
      end
      i += 3;
    end
    exp_err = expq.size() < NC;
  endtask

  task automatic run_stream(input bit mode, input int rpct,
                            input int abort_at, input bit poke,
                            output bit timed_out,
                            output bit got_err,
                            output int done_gap);
    int bi;
    int hs_cyc;
    bi = 0;
    hs_cyc = -10;
    got.delete();
    lastidx.delete();
    keep_bad = 0;
    timed_out = 1'b1;
    got_err = 1'b0;
    done_gap = -1;
    @(negedge clk);
    start = 1'b1;
    mode_i = mode;
    @(negedge clk);
    start = 1'b0;
    mode_i = ~mode;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (done) begin
        timed_out = 1'b0;
        got_err = error_o;
        done_gap = cyc - hs_cyc;
        break;
      end
      if (abort_at >= 0 && got.size() >= abort_at) begin
        timed_out = 1'b0;
        break;
      end
      t_valid_i = bi < bd.size();
      t_data_i  = t_valid_i ? bd[bi] : '0;
      t_keep_i  = t_valid_i ? bk[bi] : '0;
      t_last_i  = t_valid_i && (bi == bd.size() - 1);
      t_ready_i = $urandom_range(0, 99) < rpct;
      start     = poke && cyc == 30;
      #1;
      if (t_valid_i && t_ready_o) bi++;
      if (t_valid_o && t_ready_i) begin
        got.push_back(t_data_o);
        if (t_last_o) lastidx.push_back(got.size() - 1);
        if (t_keep_o != 3'b111) keep_bad++;
        hs_cyc = cyc;
      end
      @(negedge clk);
    end
    t_valid_i = 1'b0;
    t_last_i  = 1'b0;
    t_keep_i  = '0;
    t_ready_i = 1'b0;
    start     = 1'b0;
  endtask

  task automatic check_run(input string tag, input bit to,
                           input bit err, input int gap);
    int n;
    chk({tag, "_timeout"}, to, 0);
    chk({tag, "_count"}, got.size(), expq.size());
    n = got.size() < expq.size() ? got.size() : expq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_c%0d", tag, i), got[i], expq[i]);
    chk({tag, "_error"}, err, exp_err);
    chk({tag, "_keep"}, keep_bad, 0);
    if (expq.size() == NC) begin
      chk({tag, "_nlast"}, lastidx.size(), 1);
      if (lastidx.size() > 0)
        chk({tag, "_lastpos"}, lastidx[0], NC - 1);
    end else begin
      chk({tag, "_nlast"}, lastidx.size(), 0);
    end
    if (expq.size() > 0) chk({tag, "_donegap"}, gap, 1);
    @(negedge clk);
    chk({tag, "_donewidth"}, done, 0);
  endtask

  bit to, err;
  int gap;
  logic [255:0] beat;
  bit saw_done;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode_i = 1'b0;
    abort_i = 1'b0;
    t_data_i = '0;
    t_valid_i = 1'b0;
    t_last_i = 1'b0;
    t_keep_i = '0;
    t_ready_i = 1'b0;

    tbl[0] = '{0, 48'h000000_030201, 513, 48, 2};
    tbl[1] = '{1, 48'h000000_030201, 197121, 0, 1};
    tbl[2] = '{1, 48'h030201_7FFFFF, 197121, 0, 1};
    tbl[3] = '{1, 48'h030201_FFFFFF, 197121, 0, 1};
    tbl[4] = '{1, 48'h030201_7FE000, 8380416, 197121, 2};
    tbl[5] = '{1, 48'h030201_7FE001, 197121, 0, 1};
    tbl[6] = '{0, 48'h030201_D00D00, 3328, 3328, 2};
    tbl[7] = '{0, 48'h030201_D01D01, 513, 48, 2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_error", error_o, 0);
    chk("rst_tready", t_ready_o, 0);
    chk("rst_tvalid", t_valid_o, 0);
    chk("rst_tlast", t_last_o, 0);
    chk("rst_tdata", t_data_o, 0);
    chk("rst_tkeep", t_keep_o, 0);

    for (int v = 0; v < 8; v++) begin
      clear_stream();
      beat = rnd256();
      beat[47:0] = tbl[v].bytes;
      add_beat(beat, '1);
      for (int b = 0; b < 29; b++) add_beat(rnd256(), '1);
      run_model(tbl[v].mode);
      run_stream(tbl[v].mode, 70, -1, 0, to, err, gap);
      chk($sformatf("vec%0d_first", v),
          got.size() > 0 ? got[0] : -1, tbl[v].e0);
      if (tbl[v].ne == 2)
        chk($sformatf("vec%0d_second", v),
            got.size() > 1 ? got[1] : -1, tbl[v].e1);
      check_run($sformatf("vec%0d", v), to, err, gap);
    end

    // Random KEM stream, half-rate sink, stray start mid-run
    clear_stream();
    for (int b = 0; b < 30; b++) add_beat(rnd256(), '1);
    run_model(0);
    run_stream(0, 50, -1, 1, to, err, gap);
    check_run("kem_rand", to, err, gap);

    // Two all-FF beats: nothing accepted, stream runs dry
    clear_stream();
    add_beat('1, '1);
    add_beat('1, '1);
    run_model(0);
    run_stream(0, 100, -1, 0, to, err, gap);
    check_run("kem_exhaust", to, err, gap);

    // Four bytes per beat exercises pointer wrap
    clear_stream();
    for (int b = 0; b < 160; b++)
      add_beat(rnd256(), 32'h0000_000F);
    run_model(0);
    run_stream(0, 80, -1, 0, to, err, gap);
    check_run("kem_keepF", to, err, gap);

    // Sparse random keep including empty beats
    clear_stream();
    for (int b = 0; b < 80; b++)
      add_beat(rnd256(), (b % 7 == 3) ? 32'd0 : $urandom);
    run_model(1);
    run_stream(1, 60, -1, 0, to, err, gap);
    check_run("dsa_keep", to, err, gap);

    // Short DSA stream ends early with partial output
    clear_stream();
    add_beat(rnd256(), '1);
    add_beat(rnd256(), '1);
    run_model(1);
    run_stream(1, 90, -1, 0, to, err, gap);
    check_run("dsa_exhaust", to, err, gap);

    // Abort after 100 coefficients with the source stalled
    clear_stream();
    for (int b = 0; b < 30; b++) add_beat(rnd256(), '1);
    run_model(0);
    run_stream(0, 100, 100, 0, to, err, gap);
    chk("abort_reach", to, 0);
    chk("abort_ngot", got.size(), 100);
    for (int i = 0; i < 100 && i < got.size(); i++)
      chk($sformatf("abort_c%0d", i), got[i], expq[i]);
    repeat (3) @(negedge clk);
    chk("abort_pre_valid", t_valid_o, 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_valid", t_valid_o, 0);
    chk("abort_ready", t_ready_o, 0);
    chk("abort_done", done, 0);
    saw_done = 1'b0;
    t_ready_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done || t_valid_o || t_ready_o) saw_done = 1'b1;
    end
    t_ready_i = 1'b0;
    chk("abort_idle", saw_done, 0);
    run_stream(0, 70, -1, 0, to, err, gap);
    check_run("abort_rerun", to, err, gap);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
